// File: rtl/ftdi_fifo_async_pkg.sv
// rtl/ftdi_fifo_async_pkg.sv - shared state encodings, pin-direction constants and parameter checks
package ftdi_fifo_async_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_STROBE = 3'd1,
    ST_WR_SETUP  = 3'd2,
    ST_WR_STROBE = 3'd3,
    ST_WR_HOLD   = 3'd4,
    ST_RECOVER   = 3'd5
  } state_t;

  typedef enum logic {
    SRV_READ  = 1'b0,
    SRV_WRITE = 1'b1
  } served_t;

  localparam logic PIN_DIR_OUT = 1'b1;
  localparam logic PIN_DIR_IN  = 1'b0;

  localparam int CNT_W = 8;

  function automatic bit params_ok(input int rd_pulse, input int wr_pulse,
                                   input int recovery, input int flush_idle);
    return (rd_pulse >= 1) && (rd_pulse <= 255) &&
           (wr_pulse >= 1) && (wr_pulse <= 255) &&
           (recovery >= 3) && (recovery <= 255) &&
           (flush_idle >= 1);
  endfunction

endpackage

// File: rtl/ftdi_fifo_async_sync2.sv
// rtl/ftdi_fifo_async_sync2.sv - two-flop synchroniser with a configurable reset value
module ftdi_fifo_async_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/ftdi_fifo_async.sv
// rtl/ftdi_fifo_async.sv - FT2232H async 245 FIFO host controller; FTDI_SIWU_FLUSH_EN adds idle SIWU flush
module ftdi_fifo_async
  import ftdi_fifo_async_pkg::*;
#(
  parameter int RD_PULSE   = 3,
  parameter int WR_PULSE   = 3,
  parameter int RECOVERY   = 4,
  parameter int FLUSH_IDLE = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_dir,
  input  logic       rxf_n,
  input  logic       txe_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       siwu,
  input  logic       clkout,
  output logic       oe_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  if (!params_ok(RD_PULSE, WR_PULSE, RECOVERY, FLUSH_IDLE)) begin : g_param_check
    $error("ftdi_fifo_async: illegal RD_PULSE/WR_PULSE/RECOVERY/FLUSH_IDLE");
  end

  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_PULSE - 1);
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_PULSE - 1);
  // The IDLE decision cycle is the last of the RECOVERY high cycles, so RECOVER itself lasts one less.
  localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(RECOVERY - 2);

  state_t            state_q, state_d;
  served_t           last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              d_dir_q, d_dir_d;
  logic [7:0]        d_out_q, d_out_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;

  logic rxf_s, txe_s;
  logic rd_req, wr_grant, rd_grant, wr_start, flush_busy;
  logic unused_clkout;

  assign unused_clkout = clkout;

  ftdi_fifo_async_sync2 #(.RESET_VAL(1'b1)) u_sync_rxf (
    .clk (clk), .rst (rst), .d (rxf_n), .q (rxf_s)
  );

  ftdi_fifo_async_sync2 #(.RESET_VAL(1'b1)) u_sync_txe (
    .clk (clk), .rst (rst), .d (txe_n), .q (txe_s)
  );

  // Write grant depends only on flags and round-robin history so tx_ready never loops through tx_valid.
  always_comb begin
    rd_req   = !rxf_s && !rx_valid_q;
    wr_grant = !txe_s && (!rd_req || (last_q == SRV_READ)) && !flush_busy;
    rd_grant = rd_req && !(wr_grant && tx_valid) && !flush_busy;
    tx_ready = (state_q == ST_IDLE) && wr_grant;
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    rd_n_d     = rd_n_q;
    wr_n_d     = wr_n_q;
    d_dir_d    = d_dir_q;
    d_out_d    = d_out_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    wr_start   = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_ready && tx_valid) begin
          d_out_d  = tx_data;
          d_dir_d  = PIN_DIR_OUT;
          last_d   = SRV_WRITE;
          wr_start = 1'b1;
          state_d  = ST_WR_SETUP;
        end else if (rd_grant) begin
          rd_n_d  = 1'b0;
          cnt_d   = '0;
          last_d  = SRV_READ;
          state_d = ST_RD_STROBE;
        end
      end
      ST_RD_STROBE: begin
        if (cnt_q == RD_LAST) begin
          rx_data_d  = d_in;
          rx_valid_d = 1'b1;
          rd_n_d     = 1'b1;
          cnt_d      = '0;
          state_d    = ST_RECOVER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR_SETUP: begin
        wr_n_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_WR_STROBE;
      end
      ST_WR_STROBE: begin
        if (cnt_q == WR_LAST) begin
          wr_n_d  = 1'b1;
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR_HOLD: begin
        d_dir_d = PIN_DIR_IN;
        cnt_d   = '0;
        state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (cnt_q == REC_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= SRV_WRITE;
      cnt_q      <= '0;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      d_dir_q    <= PIN_DIR_IN;
      d_out_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      d_dir_q    <= d_dir_d;
      d_out_q    <= d_out_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

`ifdef FTDI_SIWU_FLUSH_EN
  localparam int IDLE_W = $clog2(FLUSH_IDLE + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_IDLE - 1);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              arm_q, arm_d;
  logic              siwu_q, siwu_d;

  // While siwu is low the arbiter is frozen, keeping the pulse inside IDLE.
  assign flush_busy = !siwu_q;

  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    flush_cnt_d = flush_cnt_q;
    arm_d       = arm_q;
    siwu_d      = siwu_q;
    if (wr_start) begin
      arm_d      = 1'b1;
      idle_cnt_d = '0;
    end else if (!siwu_q) begin
      if (flush_cnt_q == WR_LAST) begin
        siwu_d      = 1'b1;
        flush_cnt_d = '0;
      end else begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end else if ((state_q == ST_IDLE) && !tx_valid && !rd_grant && arm_q) begin
      if (idle_cnt_q == IDLE_LAST) begin
        siwu_d      = 1'b0;
        arm_d       = 1'b0;
        idle_cnt_d  = '0;
        flush_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
    end else begin
      idle_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q  <= '0;
      flush_cnt_q <= '0;
      arm_q       <= 1'b0;
      siwu_q      <= 1'b1;
    end else begin
      idle_cnt_q  <= idle_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      arm_q       <= arm_d;
      siwu_q      <= siwu_d;
    end
  end

  assign siwu = siwu_q;
`else
  logic unused_wr_start;

  assign unused_wr_start = wr_start;
  assign flush_busy      = 1'b0;
  assign siwu            = 1'b1;
`endif

  assign rd_n     = rd_n_q;
  assign wr_n     = wr_n_q;
  assign d_dir    = d_dir_q;
  assign d_out    = d_out_q;
  assign oe_n     = 1'b1;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: doc/ftdi_fifo_async.md
Name: ftdi_fifo_async

Overview:
Host-side controller for the FT2232H FIFO in asynchronous 245 mode. It is a drop-in replacement for ftdi_fifo_dummy, with the same pin-side ports driving the pin_bidir_8 on fifo_d. It converts the FTDI RXF#/TXE#/RD#/WR# strobe protocol into two byte streams with valid/ready handshakes: rx (host→FPGA) and tx (FPGA→host). The downstream command decoder consumes these streams.

Parameters:
RD_PULSE, 3, cycles RD# held low; data sampled on the last low cycle (min 1).
WR_PULSE, 3, cycles WR# held low (min 1).
RECOVERY, 4, idle cycles after each strobe before the next transaction; covers FTDI flag-update delay plus the 2FF synchroniser (min 3).
FLUSH_IDLE, 64, idle cycles before SIWU flush (optional feature only).

Ports:
clk  in  1  system clock, 12 MHz nominal
rst  in  1  synchronous, active-high reset
d_in  in  8  fifo_d value from pin buffer
d_out  out  8  fifo_d drive value
d_dir  out  1  1 = FPGA drives fifo_d, 0 = input
rxf_n  in  1  FTDI has data (async, low active)
txe_n  in  1  FTDI can accept data (async, low active)
rd_n  out  1  read strobe
wr_n  out  1  write strobe
siwu  out  1  send-immediate, low active
clkout  in  1  unused in async mode; present for port compatibility
oe_n  out  1  tied high (sync-mode only)
rx_data  out  8  received byte
rx_valid  out  1  rx_data valid
rx_ready  in  1  consumer accepts rx_data
tx_data  in  8  byte to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  controller accepts tx_data this cycle

Behaviour:
- Clocking and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: rd_n=1, wr_n=1, siwu=1, oe_n=1, d_dir=0, d_out=0, rx_valid=0, rx_data=0, tx_ready=0, state=IDLE, last_served=WRITE.
- rxf_n and txe_n each pass through a 2FF synchroniser (reset value 1). Decisions use only the synchronised values rxf_s and txe_s.
- States are IDLE, RD_STROBE, WR_SETUP, WR_STROBE, WR_HOLD, RECOVER.
- Request conditions:
  - rd_req = !rxf_s && !rx_valid (one-byte output register; no read while it is full).
  - wr_req = !txe_s && tx_valid.
- tx_ready = (state==IDLE) && wr_grant. It is combinational from state and flags, not from tx_valid.
- IDLE arbitration:
  - Both requests: grant opposite of last_served (round-robin).
  - Single request: grant it. None: stay in IDLE.
- Read path:
  - IDLE→RD_STROBE: rd_n=0 for RD_PULSE cycles.
  - On the last cycle, rx_data<=d_in and rx_valid<=1; rd_n=1 from the next cycle.
  - Then →RECOVER.
- Write path:
  - IDLE with tx handshake: latch tx_data into d_out, d_dir<=1, →WR_SETUP (1 cycle, data driven, wr_n=1).
  - →WR_STROBE: wr_n=0 for WR_PULSE cycles.
  - →WR_HOLD: 1 cycle, wr_n=1, data still driven.
  - d_dir<=0 on exit, →RECOVER.
- RECOVER: RECOVERY cycles with all strobes high and d_dir=0, then →IDLE.
- rx handshake: rx_valid clears on rx_valid&&rx_ready. It may clear in the same cycle a new read begins, but a read never starts while rx_valid=1.
- Bus rule: d_dir=1 only in WR_SETUP/WR_STROBE/WR_HOLD. rd_n=0 and d_dir=1 never occur in the same cycle.
- Throughput: a read takes RD_PULSE+RECOVERY cycles; a write takes WR_PULSE+2+RECOVERY cycles.
- Reset mid-operation: the next cycle returns every output to its reset value. A byte in flight is lost; the FTDI tolerates an aborted strobe.
- Flag deassert mid-strobe is ignored; the transaction completes.

Optional Feature:
FTDI_SIWU_FLUSH_EN.
- When defined, after at least one write, if FLUSH_IDLE consecutive cycles pass in IDLE with tx_valid=0:
  - siwu is driven low for WR_PULSE cycles, then high.
  - This pulse occurs only while in IDLE.
  - The arm is cleared until the next write.
- When undefined, siwu is constant 1 and the idle counter is not built.

Decomposition:
- Shared include ftdi_defs.vh holds:
  - the state encodings;
  - the PIN_DIR_OUT/PIN_DIR_IN constants used with pin_bidir;
  - minimum-parameter checks (RECOVERY>=3, pulses>=1).
- One natural sub-module, sync2: a 2-flop synchroniser with a reset value parameter, instantiated for rxf_n and txe_n.

Test Plan:
- Host byte 0xA5, rxf_n low, rx_ready=1 → rd_n low for exactly 3 cycles; rx_data=0xA5 with rx_valid for one cycle; next rd_n no earlier than 4 cycles later.
- rx_ready=0 with 3 bytes pending → exactly one read occurs, rd_n stays high until rx_ready; bytes 0x01,0x02,0x03 delivered in order.
- tx_valid with 0x3C, txe_n low → d_dir=1 one cycle before wr_n falls; wr_n low 3 cycles; d_out=0x3C throughout; d_dir=0 one cycle after wr_n rises.
- rxf_n and txe_n both low with continuous traffic → transactions alternate R,W,R,W; no cycle with d_dir=1 and rd_n=0.
- rst asserted in the 2nd cycle of RD_STROBE → next cycle rd_n=1, rx_valid=0, state IDLE; with txe_n high, tx_ready stays 0.
- With FTDI_SIWU_FLUSH_EN: write 0x55, then idle 64 cycles → siwu low for 3 cycles once; no further pulse without another write.
